// File: rtl/lsu_req_ctrl.sv
// Initiator-side LSU request controller: one outstanding load/store with a fixed read latency.
// Optional macro LSU_REQ_CTRL_POSTED_STORE_EN: stores complete without a response.
module lsu_req_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDRESS_SPACE  = 4096,
    parameter int unsigned NUM_DATA_TYPES = 6,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned RD_WIDTH       = 5,
    localparam int unsigned AW = $clog2(ADDRESS_SPACE),
    localparam int unsigned DW = $clog2(NUM_DATA_TYPES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic                  req_we_in,
    input  logic [AW-1:0]         req_addr_in,
    input  logic [DATA_WIDTH-1:0] req_data_in,
    input  logic [DW-1:0]         req_dtype_in,
    input  logic [RD_WIDTH-1:0]   req_rd_in,
    output logic [AW-1:0]         lsu_addr_out,
    output logic [DATA_WIDTH-1:0] lsu_data_out,
    output logic                  lsu_we_out,
    output logic [DW-1:0]         lsu_dtypes_out,
    input  logic [DATA_WIDTH-1:0] lsu_data_in,
    output logic                  rsp_valid_out,
    input  logic                  rsp_ready_in,
    output logic [DATA_WIDTH-1:0] rsp_data_out,
    output logic [RD_WIDTH-1:0]   rsp_rd_out,
    output logic                  rsp_err_out
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    localparam logic [DW-1:0] DtHalf  = DW'(1);
    localparam logic [DW-1:0] DtWord  = DW'(2);
    localparam logic [DW-1:0] DtHalfU = DW'(4);

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  is_store_q, is_store_d;
    logic [RD_WIDTH-1:0]   rd_q, rd_d;
    logic                  req_ready_q, req_ready_d;
    logic [AW-1:0]         lsu_addr_q, lsu_addr_d;
    logic [DATA_WIDTH-1:0] lsu_data_q, lsu_data_d;
    logic                  lsu_we_q, lsu_we_d;
    logic [DW-1:0]         lsu_dtypes_q, lsu_dtypes_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [RD_WIDTH-1:0]   rsp_rd_q, rsp_rd_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  req_err;
    logic                  done;

    always_comb begin
        req_err = (req_dtype_in > DtHalfU)
               || (((req_dtype_in == DtHalf) || (req_dtype_in == DtHalfU)) && req_addr_in[0])
               || ((req_dtype_in == DtWord) && (req_addr_in[1:0] != 2'b00));
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_store_d   = is_store_q;
        rd_d         = rd_q;
        req_ready_d  = req_ready_q;
        lsu_addr_d   = lsu_addr_q;
        lsu_data_d   = lsu_data_q;
        lsu_we_d     = 1'b0;
        lsu_dtypes_d = lsu_dtypes_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_rd_d     = rsp_rd_q;
        rsp_err_d    = rsp_err_q;
        done         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid_in && req_ready_q) begin
                    req_ready_d = 1'b0;
                    is_store_d  = req_we_in;
                    rd_d        = req_we_in ? '0 : req_rd_in;
                    if (req_err) begin
                        // Rejected requests never reach the LSU bus.
                        state_d     = StResp;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_data_d  = '0;
                        rsp_rd_d    = req_we_in ? '0 : req_rd_in;
                    end else begin
                        lsu_addr_d   = req_addr_in;
                        lsu_data_d   = req_data_in;
                        lsu_dtypes_d = req_dtype_in;
                        lsu_we_d     = req_we_in;
                        state_d      = StIssue;
                    end
                end
            end
            StIssue: begin
                cnt_d = 4'(READ_LATENCY - 1);
`ifdef LSU_REQ_CTRL_POSTED_STORE_EN
                if (is_store_q) begin
                    state_d     = StIdle;
                    req_ready_d = 1'b1;
                end else if (READ_LATENCY == 1) begin
                    done = 1'b1;
                end else begin
                    state_d = StWait;
                end
`else
                if (READ_LATENCY == 1) begin
                    done = 1'b1;
                end else begin
                    state_d = StWait;
                end
`endif
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done = 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (done) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_data_d  = is_store_q ? '0 : lsu_data_in;
            rsp_rd_d    = rd_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            is_store_q   <= 1'b0;
            rd_q         <= '0;
            req_ready_q  <= 1'b1;
            lsu_addr_q   <= '0;
            lsu_data_q   <= '0;
            lsu_we_q     <= 1'b0;
            lsu_dtypes_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_rd_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_store_q   <= is_store_d;
            rd_q         <= rd_d;
            req_ready_q  <= req_ready_d;
            lsu_addr_q   <= lsu_addr_d;
            lsu_data_q   <= lsu_data_d;
            lsu_we_q     <= lsu_we_d;
            lsu_dtypes_q <= lsu_dtypes_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign req_ready_out  = req_ready_q;
    assign lsu_addr_out   = lsu_addr_q;
    assign lsu_data_out   = lsu_data_q;
    assign lsu_we_out     = lsu_we_q;
    assign lsu_dtypes_out = lsu_dtypes_q;
    assign rsp_valid_out  = rsp_valid_q;
    assign rsp_data_out   = rsp_data_q;
    assign rsp_rd_out     = rsp_rd_q;
    assign rsp_err_out    = rsp_err_q;

endmodule

// File: tb/tb_lsu_req_ctrl.sv
// Scoreboard bench for lsu_req_ctrl: a byte-memory LSU model behind a latency-1 instance,
// plus a latency-3 instance fed a cycle-stamped read bus to pin down the sampling edge.
module tb_lsu_req_ctrl;

    typedef struct {
        logic        err;
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } exp_t;

`ifdef LSU_REQ_CTRL_POSTED_STORE_EN
    localparam bit Posted = 1'b1;
`else
    localparam bit Posted = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        reset3 = 1'b1;
    logic        req_valid_in = 1'b0;
    logic        req_valid3 = 1'b0;
    logic        req_we_in = 1'b0;
    logic [11:0] req_addr_in = '0;
    logic [31:0] req_data_in = '0;
    logic [2:0]  req_dtype_in = '0;
    logic [4:0]  req_rd_in = '0;
    logic        rsp_ready_in = 1'b1;
    logic        rsp_ready3 = 1'b1;

    logic        req_ready_out, lsu_we_out, rsp_valid_out, rsp_err_out;
    logic [11:0] lsu_addr_out;
    logic [31:0] lsu_data_out, lsu_data_in, rsp_data_out;
    logic [2:0]  lsu_dtypes_out;
    logic [4:0]  rsp_rd_out;

    logic        req_ready3, lsu_we3, rsp_valid3, rsp_err3;
    logic [11:0] lsu_addr3;
    logic [31:0] lsu_wdata3, lsu_rdata3, rsp_data3;
    logic [2:0]  lsu_dtypes3;
    logic [4:0]  rsp_rd3;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lsu_req_ctrl #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_we_in(req_we_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_dtype_in(req_dtype_in),
        .req_rd_in(req_rd_in), .lsu_addr_out(lsu_addr_out), .lsu_data_out(lsu_data_out),
        .lsu_we_out(lsu_we_out), .lsu_dtypes_out(lsu_dtypes_out), .lsu_data_in(lsu_data_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_data_out(rsp_data_out), .rsp_rd_out(rsp_rd_out), .rsp_err_out(rsp_err_out)
    );

    lsu_req_ctrl #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset3),
        .req_valid_in(req_valid3), .req_ready_out(req_ready3), .req_we_in(req_we_in),
        .req_addr_in(req_addr_in), .req_data_in(req_data_in), .req_dtype_in(req_dtype_in),
        .req_rd_in(req_rd_in), .lsu_addr_out(lsu_addr3), .lsu_data_out(lsu_wdata3),
        .lsu_we_out(lsu_we3), .lsu_dtypes_out(lsu_dtypes3), .lsu_data_in(lsu_rdata3),
        .rsp_valid_out(rsp_valid3), .rsp_ready_in(rsp_ready3),
        .rsp_data_out(rsp_data3), .rsp_rd_out(rsp_rd3), .rsp_err_out(rsp_err3)
    );

    // Read bus stamped with the current cycle number.
    assign lsu_rdata3 = {16'hC0DE, cyc[15:0]};

    logic [7:0] mem [4096];
    logic [7:0] ref_mem [4096];

    function automatic logic [31:0] ext(input logic [2:0] dt, input logic [31:0] raw);
        case (dt)
            3'd0:    return {{24{raw[7]}}, raw[7:0]};
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd3:    return {24'h0, raw[7:0]};
            3'd4:    return {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign lsu_data_in = ext(lsu_dtypes_out, {mem[lsu_addr_out + 12'd3], mem[lsu_addr_out + 12'd2],
                                              mem[lsu_addr_out + 12'd1], mem[lsu_addr_out]});

    always @(posedge clk) begin
        if (lsu_we_out) begin
            mem[lsu_addr_out] <= lsu_data_out[7:0];
            if (lsu_dtypes_out == 3'd1 || lsu_dtypes_out == 3'd4 || lsu_dtypes_out == 3'd2)
                mem[lsu_addr_out + 12'd1] <= lsu_data_out[15:8];
            if (lsu_dtypes_out == 3'd2) begin
                mem[lsu_addr_out + 12'd2] <= lsu_data_out[23:16];
                mem[lsu_addr_out + 12'd3] <= lsu_data_out[31:24];
            end
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    exp_t sb[$];
    int   hold_cnt = 0;
    bit   valid_seen = 0;
    bit   chk_rdy = 0;
    int   first_cyc = 0;
    logic [31:0] held_data;
    logic [4:0]  held_rd;
    int   we_cnt = 0;
    int   we_cyc = 0;
    logic [11:0] we_addr;
    logic [2:0]  we_dt;

    always @(negedge clk) begin
        if (lsu_we_out) begin
            we_cnt++;
            we_cyc  = cyc;
            we_addr = lsu_addr_out;
            we_dt   = lsu_dtypes_out;
        end
    end

    // Response monitor: applies back-pressure, checks stability and pops the scoreboard.
    always @(negedge clk) begin
        if (chk_rdy) begin
            check("rdy_after_rsp", {31'b0, req_ready_out}, 32'd1);
            chk_rdy = 0;
        end
        if (!reset && rsp_valid_out) begin
            if (!valid_seen) begin
                valid_seen = 1;
                first_cyc  = cyc;
                held_data  = rsp_data_out;
                held_rd    = rsp_rd_out;
            end else begin
                check("hold_data", rsp_data_out, held_data);
                check("hold_rd", {27'b0, rsp_rd_out}, {27'b0, held_rd});
            end
            if (hold_cnt > 0) begin
                hold_cnt--;
                rsp_ready_in = 1'b0;
                check("hold_req_rdy", {31'b0, req_ready_out}, 32'd0);
            end else begin
                rsp_ready_in = 1'b1;
                valid_seen   = 0;
                if (sb.size() == 0) begin
                    check("unexpected_rsp", {31'b0, rsp_valid_out}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_err", {31'b0, rsp_err_out}, {31'b0, e.err});
                    check("rsp_data", rsp_data_out, e.data);
                    check("rsp_rd", {27'b0, rsp_rd_out}, {27'b0, e.rd});
                    check("rsp_latency", first_cyc, e.due);
                    chk_rdy = 1;
                end
            end
        end
    end

    task automatic send(input logic we, input logic [11:0] a, input logic [31:0] d,
                        input logic [2:0] dt, input logic [4:0] rd, output int t);
        exp_t e;
        bit   err;
        int   waitc;
        @(negedge clk);
        req_we_in = we; req_addr_in = a; req_data_in = d; req_dtype_in = dt; req_rd_in = rd;
        req_valid_in = 1'b1;
        waitc = 0;
        while (!req_ready_out && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready_out) begin
            check("accept_timeout", {31'b0, req_ready_out}, 32'd1);
            req_valid_in = 1'b0;
            t = -1;
            return;
        end
        t   = cyc;
        err = (dt > 3'd4) || ((dt == 3'd1 || dt == 3'd4) && a[0]) || (dt == 3'd2 && a[1:0] != 2'b00);
        e.err  = err;
        e.rd   = we ? 5'd0 : rd;
        e.data = '0;
        e.due  = err ? t + 1 : t + 2;
        if (!err && we) begin
            ref_mem[a] = d[7:0];
            if (dt == 3'd1 || dt == 3'd4 || dt == 3'd2) ref_mem[a + 12'd1] = d[15:8];
            if (dt == 3'd2) begin
                ref_mem[a + 12'd2] = d[23:16];
                ref_mem[a + 12'd3] = d[31:24];
            end
        end
        if (!err && !we)
            e.data = ext(dt, {ref_mem[a + 12'd3], ref_mem[a + 12'd2], ref_mem[a + 12'd1], ref_mem[a]});
        if (!(Posted && we && !err)) sb.push_back(e);
        @(posedge clk);
        #1 req_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        int t;
        int w0;
        int seen;
        logic [11:0] a0;
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0; reset3 = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready_out}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid_out}, 32'd0);
        check("rst_lsu_we", {31'b0, lsu_we_out}, 32'd0);
        check("rst_lsu_addr", {20'b0, lsu_addr_out}, 32'd0);
        check("rst_rsp_data", rsp_data_out, 32'd0);
        check("rst_req_ready3", {31'b0, req_ready3}, 32'd1);

        // Store word then load it back.
        w0 = we_cnt;
        send(1'b1, 12'h000, 32'hABCDEF00, 3'd2, 5'd3, t);
        drain();
        check("st_we_count", we_cnt - w0, 1);
        check("st_we_cycle", we_cyc, t + 1);
        check("st_we_addr", {20'b0, we_addr}, 32'h000);
        check("st_we_dtype", {29'b0, we_dt}, 32'd2);
        send(1'b0, 12'h000, 32'h0, 3'd2, 5'd7, t);
        drain();

        // Misaligned and illegal requests never touch the bus.
        w0 = we_cnt;
        a0 = lsu_addr_out;
        send(1'b0, 12'h013, 32'h0, 3'd1, 5'd9, t);
        send(1'b0, 12'h00A, 32'h0, 3'd2, 5'd10, t);
        send(1'b1, 12'h00A, 32'h12345678, 3'd2, 5'd11, t);
        send(1'b0, 12'h020, 32'h0, 3'd5, 5'd12, t);
        drain();
        check("err_no_we", we_cnt - w0, 0);
        check("err_addr_kept", {20'b0, lsu_addr_out}, {20'b0, a0});

        // Signed and unsigned byte/half loads.
        send(1'b1, 12'h01A, 32'h000000AB, 3'd0, 5'd1, t);
        send(1'b0, 12'h01A, 32'h0, 3'd0, 5'd2, t);
        send(1'b0, 12'h01A, 32'h0, 3'd3, 5'd4, t);
        send(1'b1, 12'h040, 32'h00008001, 3'd1, 5'd1, t);
        send(1'b0, 12'h040, 32'h0, 3'd1, 5'd5, t);
        send(1'b0, 12'h040, 32'h0, 3'd4, 5'd6, t);
        drain();

        // Back-pressure for three cycles.
        hold_cnt = 3;
        send(1'b0, 12'h000, 32'h0, 3'd2, 5'd31, t);
        drain();

        // Word store near the top of the address space.
        w0 = we_cnt;
        send(1'b1, 12'hEF0, 32'h000000AB, 3'd2, 5'd8, t);
        if (Posted) begin
            @(negedge clk);
            @(negedge clk);
            check("posted_ready_t2", {31'b0, req_ready_out}, 32'd1);
            check("posted_no_rsp", {31'b0, rsp_valid_out}, 32'd0);
        end
        drain();
        check("ef0_we_count", we_cnt - w0, 1);
        check("ef0_we_addr", {20'b0, we_addr}, 32'hEF0);
        send(1'b0, 12'hEF0, 32'h0, 3'd2, 5'd13, t);
        drain();

        // Latency-3 instance: sampling edge, then reset mid-flight.
        @(negedge clk);
        req_we_in = 1'b0; req_addr_in = 12'h004; req_dtype_in = 3'd2; req_rd_in = 5'd17;
        req_valid3 = 1'b1;
        check("rl3_ready", {31'b0, req_ready3}, 32'd1);
        t = cyc;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp_valid3) begin
                seen = 1;
                check("rl3_latency", cyc, t + 4);
                check("rl3_data", rsp_data3, {16'hC0DE, 16'(t + 3)});
                check("rl3_rd", {27'b0, rsp_rd3}, 32'd17);
            end
        end
        check("rl3_rsp_seen", seen, 1);

        @(negedge clk);
        req_valid3 = 1'b1;
        t = cyc;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset3 = 1'b1;
        @(posedge clk);
        #1 reset3 = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid3) seen++;
        end
        check("rl3_rst_no_rsp", seen, 0);
        check("rl3_rst_ready", {31'b0, req_ready3}, 32'd1);
        check("rl3_rst_we", {31'b0, lsu_we3}, 32'd0);

        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
